// File: rtl/sipo_pkg.sv
// Shared types for the serial-to-parallel word receiver.
package sipo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2
  } state_e;

  // Bit counter must reach WIDTH (parity slot) without wrapping.
  function automatic int cnt_width(input int w);
    return $clog2(w + 2);
  endfunction

endpackage

// File: rtl/sipo_hold.sv
// Output holding register: valid/ready handshake, overrun pulse, parity flag.
module sipo_hold
  import sipo_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             word_done_i,
  input  logic [WIDTH-1:0] word_i,
  input  logic             perr_i,
  input  logic             ready_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             valid_o,
  output logic             parity_err_o,
  output logic             overrun_o
);

  logic [WIDTH-1:0] dout_q, dout_d;
  logic             valid_q, valid_d;
  logic             perr_q, perr_d;
  logic             ovr_q, ovr_d;

  always_comb begin
    dout_d  = dout_q;
    valid_d = valid_q;
    perr_d  = perr_q;
    ovr_d   = 1'b0;
    if (word_done_i) begin
      // A consumer taking the old word on this edge frees the slot for the new one.
      if (!valid_q || ready_i) begin
        dout_d  = word_i;
        valid_d = 1'b1;
        perr_d  = perr_i;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      dout_q  <= dout_d;
      valid_q <= valid_d;
      perr_q  <= perr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign dout_o       = dout_q;
  assign valid_o      = valid_q;
  assign parity_err_o = perr_q;
  assign overrun_o    = ovr_q;

endmodule

// File: rtl/sipo.sv
// LSB-first serial-to-parallel receiver aligned by a sync marker.
// Define SIPO_PARITY_EN to receive and check a trailing even-parity bit.
module sipo
  import sipo_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ser,
  input  logic             ser_en,
  input  logic             sync,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  input  logic             ready,
  output logic             overrun,
  output logic             parity_err
);

  localparam int CW = cnt_width(WIDTH);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic             done;
  logic             perr;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    done    = 1'b0;
    perr    = 1'b0;
    if (ser_en) begin
      if (sync) begin
        // sync always restarts; any partial word is silently dropped
        sh_d    = '0;
        sh_d[0] = ser;
        cnt_d   = CW'(1);
        state_d = SHIFT;
      end else begin
        case (state_q)
          SHIFT: begin
            // bit k lands at index k: same result as shifting into the MSB and right-shifting
            for (int i = 0; i < WIDTH; i++)
              if (cnt_q == CW'(i)) sh_d[i] = ser;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
`ifdef SIPO_PARITY_EN
              state_d = PAR;
`else
              done    = 1'b1;
              cnt_d   = '0;
              state_d = IDLE;
`endif
            end
          end
`ifdef SIPO_PARITY_EN
          PAR: begin
            done    = 1'b1;
            perr    = (^sh_q) ^ ser;
            cnt_d   = '0;
            state_d = IDLE;
          end
`endif
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
    end
  end

  sipo_hold #(.WIDTH(WIDTH)) u_hold (
    .clk          (clk),
    .rst          (rst),
    .word_done_i  (done),
    .word_i       (sh_d),
    .perr_i       (perr),
    .ready_i      (ready),
    .dout_o       (dout),
    .valid_o      (valid),
    .parity_err_o (parity_err),
    .overrun_o    (overrun)
  );

endmodule

// File: tb/tb_sipo.sv
// Bench for sipo: directed scenarios plus random traffic against a word-level model.
module tb_sipo;

  localparam int W = 8;
`ifdef SIPO_PARITY_EN
  localparam int NB = W + 1;
`else
  localparam int NB = W;
`endif

  logic         clk = 1'b0;
  logic         rst, ser, ser_en, sync, ready;
  logic [W-1:0] dout;
  logic         valid, overrun, parity_err;

  int checks   = 0;
  int failures = 0;

  // reference model state: collected bits of the frame in progress and the held word
  bit           m_act;
  bit           mq[$];
  logic         m_v, m_ovr, m_pe;
  logic [W-1:0] m_d;

  always #5 clk = ~clk;

  sipo #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .ser        (ser),
    .ser_en     (ser_en),
    .sync       (sync),
    .dout       (dout),
    .valid      (valid),
    .ready      (ready),
    .overrun    (overrun),
    .parity_err (parity_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_step(input logic s, input logic en, input logic sy,
                            input logic rdy, input logic r);
    logic         done, pe;
    logic [W-1:0] w;
    done = 1'b0;
    pe   = 1'b0;
    w    = '0;
    if (r) begin
      m_act = 1'b0;
      mq.delete();
      m_v = 1'b0; m_ovr = 1'b0; m_pe = 1'b0; m_d = '0;
      return;
    end
    if (en) begin
      if (sy) begin
        mq.delete();
        mq.push_back(s);
        m_act = 1'b1;
      end else if (m_act) begin
        mq.push_back(s);
      end
    end
    if (m_act && mq.size() == NB) begin
      for (int i = 0; i < W; i++) w[i] = mq[i];
`ifdef SIPO_PARITY_EN
      for (int i = 0; i < NB; i++) pe = pe ^ mq[i];
`endif
      done  = 1'b1;
      m_act = 1'b0;
      mq.delete();
    end
    m_ovr = 1'b0;
    if (done) begin
      if (!m_v || rdy) begin
        m_v = 1'b1; m_d = w; m_pe = pe;
      end else begin
        m_ovr = 1'b1;
      end
    end else if (m_v && rdy) begin
      m_v = 1'b0;
    end
  endtask

  task automatic cyc(input logic s, input logic en, input logic sy,
                     input logic rdy, input logic r);
    ser = s; ser_en = en; sync = sy; ready = rdy; rst = r;
    @(posedge clk);
    model_step(s, en, sy, rdy, r);
    #1;
    chk("valid", {31'd0, valid}, {31'd0, m_v});
    chk("overrun", {31'd0, overrun}, {31'd0, m_ovr});
    if (m_v) begin
      chk("dout", {24'd0, dout}, {24'd0, m_d});
      chk("parity_err", {31'd0, parity_err}, {31'd0, m_pe});
    end
  endtask

  task automatic send_word(input logic [W-1:0] w, input logic rdy, input logic pb);
    for (int i = 0; i < W; i++) cyc(w[i], 1'b1, i == 0, rdy, 1'b0);
`ifdef SIPO_PARITY_EN
    cyc(pb, 1'b1, 1'b0, rdy, 1'b0);
`else
    if (pb) ;
`endif
  endtask

  function automatic logic even_pb(input logic [W-1:0] w);
    return ^w;
  endfunction

  initial begin
    logic [W-1:0] pw;
    m_act = 1'b0; m_v = 1'b0; m_ovr = 1'b0; m_pe = 1'b0; m_d = '0;
    ser = 1'b0; ser_en = 1'b0; sync = 1'b0; ready = 1'b0; rst = 1'b1;

    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    chk("rst_dout", {24'd0, dout}, 32'd0);
    chk("rst_perr", {31'd0, parity_err}, 32'd0);

    // first word held with no consumer
    send_word(8'h4D, 1'b0, even_pb(8'h4D));
    chk("w4D_dout", {24'd0, dout}, 32'h4D);
    chk("w4D_valid", {31'd0, valid}, 32'd1);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);

    // second word dropped
    send_word(8'hA5, 1'b0, even_pb(8'hA5));
    chk("ovr_pulse", {31'd0, overrun}, 32'd1);
    cyc(0, 0, 0, 0, 0);
    chk("ovr_one_cycle", {31'd0, overrun}, 32'd0);
    chk("ovr_kept", {24'd0, dout}, 32'h4D);
    cyc(0, 0, 0, 1, 0);
    chk("consumed", {31'd0, valid}, 32'd0);

    // back-to-back with a ready consumer
    send_word(8'h01, 1'b1, even_pb(8'h01));
    chk("b2b_01", {24'd0, dout}, 32'h01);
    send_word(8'hFF, 1'b1, even_pb(8'hFF));
    chk("b2b_FF", {24'd0, dout}, 32'hFF);
    cyc(0, 0, 0, 1, 0);

    // partial word abandoned by an early sync
    pw = 8'h5A;
    for (int i = 0; i < 4; i++) cyc(pw[i], 1'b1, i == 0, 1'b0, 1'b0);
    send_word(8'h3C, 1'b0, even_pb(8'h3C));
    chk("resync_3C", {24'd0, dout}, 32'h3C);
    cyc(0, 0, 0, 1, 0);

    // reset mid-word
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, i == 0, 1'b0, 1'b0);
    cyc(0, 0, 0, 0, 1);
    chk("rst_mid_valid", {31'd0, valid}, 32'd0);
    cyc(1, 1, 0, 0, 1);
    send_word(8'h81, 1'b0, even_pb(8'h81));
    chk("post_rst_81", {24'd0, dout}, 32'h81);
    cyc(0, 0, 0, 1, 0);

`ifdef SIPO_PARITY_EN
    send_word(8'h03, 1'b0, 1'b0);
    chk("par_ok", {31'd0, parity_err}, 32'd0);
    cyc(0, 0, 0, 1, 0);
    send_word(8'h07, 1'b0, 1'b0);
    chk("par_bad", {31'd0, parity_err}, 32'd1);
    chk("par_bad_dout", {24'd0, dout}, 32'h07);
    cyc(0, 0, 0, 1, 0);
`endif

    // random traffic
    for (int n = 0; n < 3000; n++)
      cyc(1'($urandom_range(1)), $urandom_range(9) < 7, $urandom_range(11) == 0,
          $urandom_range(1) == 1, $urandom_range(199) == 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
